// File: rtl/dekatron_step_controller_pkg.sv
// Shared types and constants for the dekatron step controller slice.
package dekatron_step_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // One step is three En clocks at the sender: NONE -> RIGHT -> LEFT.
  localparam int PULSE_PHASES = 3;
  localparam int PHASE_W      = $clog2(PULSE_PHASES);
  localparam int POS_W        = 4;

  // Out-of-range resync values collapse to cathode 0.
  function automatic logic [POS_W-1:0] clip_pos(input logic [POS_W-1:0] v, input int n);
    return (int'(v) >= n) ? '0 : v;
  endfunction

endpackage

// File: rtl/dekatron_step_controller_if.sv
// Request/status bus between a move requester and the dekatron step controller.
interface dekatron_step_controller_if #(
  parameter int COUNT_WIDTH = 4
);
  logic                   Request;
  logic                   Reverse;
  logic [COUNT_WIDTH-1:0] Steps;
  logic                   Load;
  logic [3:0]             LoadValue;
  logic                   Busy;
  logic                   Done;
  logic [3:0]             Position;
  logic                   Carry;

  modport master (
    output Request, Reverse, Steps, Load, LoadValue,
    input  Busy, Done, Position, Carry
  );

  modport slave (
    input  Request, Reverse, Steps, Load, LoadValue,
    output Busy, Done, Position, Carry
  );
endinterface

// File: rtl/dekatron_step_controller_position_counter.sv
// Modulo-DEKATRON_NUM up/down cathode counter with resync load and wrap pulse.
module dekatron_step_controller_position_counter
  import dekatron_step_controller_pkg::*;
#(
  parameter int DEKATRON_NUM = 10
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic [POS_W-1:0] load_value,
  input  logic             step,
  input  logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             carry
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(DEKATRON_NUM - 1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pos   <= '0;
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (load) begin
        pos <= clip_pos(load_value, DEKATRON_NUM);
      end else if (step) begin
        if (!dir) begin
          if (pos == POS_MAX) begin
            pos   <= '0;
            carry <= 1'b1;
          end else begin
            pos <= pos + 1'b1;
          end
        end else begin
          if (pos == '0) begin
            pos   <= POS_MAX;
            carry <= 1'b1;
          end else begin
            pos <= pos - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dekatron_step_controller.sv
// Sequences N three-clock En bursts to the dekatron pulse sender with settle gaps, tracking position.
module dekatron_step_controller
  import dekatron_step_controller_pkg::*;
#(
  parameter int DEKATRON_NUM  = 10,
  parameter int COUNT_WIDTH   = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  dekatron_step_controller_if.slave  bus,
  output logic                       PulseEn,
  output logic                       PulseReverse
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t               state_q, state_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 rev_d;
  logic                 load;
  logic                 step;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    rev_d    = PulseReverse;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Load wins over Request so a resync never races a move.
        if (bus.Load) begin
          load = 1'b1;
        end else if (bus.Request) begin
          rev_d = bus.Reverse;
          if (bus.Steps != '0) begin
            rem_d   = bus.Steps;
            phase_d = '0;
            state_d = ST_PULSE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PULSE: begin
        if (phase_q == PHASE_W'(PULSE_PHASES - 1)) begin
          step     = 1'b1;
          rem_d    = rem_q - 1'b1;
          phase_d  = '0;
          settle_d = '0;
          if (SETTLE_CYCLES > 0)             state_d = ST_SETTLE;
          else if (rem_q != COUNT_WIDTH'(1)) state_d = ST_PULSE;
          else                               state_d = ST_DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (int'(settle_q) + 1 >= SETTLE_CYCLES) begin
          settle_d = '0;
          state_d  = (rem_q != '0) ? ST_PULSE : ST_DONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      phase_q      <= '0;
      settle_q     <= '0;
      PulseEn      <= 1'b0;
      PulseReverse <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      phase_q      <= phase_d;
      settle_q     <= settle_d;
      PulseEn      <= (state_d == ST_PULSE);
      PulseReverse <= rev_d;
      bus.Busy     <= (state_d == ST_PULSE) || (state_d == ST_SETTLE);
      bus.Done     <= (state_d == ST_DONE);
    end
  end

  dekatron_step_controller_position_counter #(
    .DEKATRON_NUM(DEKATRON_NUM)
  ) u_pos (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load       (load),
    .load_value (bus.LoadValue),
    .step       (step),
    .dir        (PulseReverse),
    .pos        (bus.Position),
    .carry      (bus.Carry)
  );

endmodule
